// File: rtl/mac_pkg.sv
// Shared types and constants for the neuron multiply-accumulate block.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package mac_pkg;

  // Control states of the MAC sequencer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest accumulator the saturation-bound helpers support
  localparam int ACC_W_LIMIT = 128;

  // Largest positive value of a signed accumulator of width w
  function automatic logic [ACC_W_LIMIT-1:0] acc_max(input int w);
    logic [ACC_W_LIMIT-1:0] one;
    one = ACC_W_LIMIT'(1);
    return (one << (w - 1)) - one;
  endfunction

  // Most negative value of a signed accumulator of width w (bit pattern 100..0)
  function automatic logic [ACC_W_LIMIT-1:0] acc_min(input int w);
    logic [ACC_W_LIMIT-1:0] one;
    one = ACC_W_LIMIT'(1);
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Signed saturating adder: sum = clamp(a + b) to the ACC_W signed range, ovf flags a clamp.
// Latency: combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W = 64
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic [ACC_W-1:0] raw;
  logic             same_sign;
  logic             sign_flip;

  assign raw = a + b;

  // Two's-complement overflow: operands agree in sign but the wrapped sum does not
  always_comb begin
    same_sign = (a[ACC_W-1] == b[ACC_W-1]);
    sign_flip = (raw[ACC_W-1] != a[ACC_W-1]);
    ovf       = same_sign && sign_flip;
    sum       = raw;
    if (ovf) begin
      sum = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/mod_neuron_mac.sv
// Sequential MAC for one hidden neuron: h0 = bias + sum(x[i]*w[i]) with saturation, feeding the sigmoid.
// Latency: last pair accepted in cycle k -> h0 and the h0_valid pulse appear in cycle k+2.
// Backpressure: in_ready is high only while accumulating; x_valid low stalls, nothing is buffered.
module mod_neuron_mac
  import mac_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ACC_W-1:0]  bias,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              in_ready,
  output logic              busy,
  output logic [ACC_W-1:0]  h0,
  output logic              h0_valid,
  output logic              ovf
);

  localparam int               CNT_W    = $clog2(N_INPUTS + 1);
  localparam int               PROD_W   = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  state_t                    state;
  logic [CNT_W-1:0]          count;
  logic signed [PROD_W-1:0]  prod;
  logic                      prod_vld;
  logic [ACC_W-1:0]          acc;

  logic                      accept;
  logic                      start_ok;
  logic signed [PROD_W-1:0]  x_ext;
  logic signed [PROD_W-1:0]  w_ext;
  logic signed [PROD_W-1:0]  mult;
  logic [ACC_W-1:0]          prod_ext;
  logic [ACC_W-1:0]          sum;
  logic                      sum_ovf;

  // A pair is taken only while accumulating; start only counts from IDLE
  assign accept   = x_valid && in_ready;
  assign start_ok = (state == IDLE) && start;

  // Full-precision signed product: both operands widened first so nothing is lost
  assign x_ext    = PROD_W'($signed(x_in));
  assign w_ext    = PROD_W'($signed(w_in));
  assign mult     = x_ext * w_ext;

  // Sign-extend the registered product to accumulator width
  assign prod_ext = ACC_W'(prod);

  mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // Stage 1: register the product of each accepted pair
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod <= mult;
      end
    end
  end

  // Stage 2: load bias on start, otherwise fold each valid product in with saturation
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_ok) begin
      acc <= bias;
      ovf <= 1'b0;
    end else if (prod_vld) begin
      acc <= sum;
      if (sum_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

  // Sequencer: beat counting, handshake and result publication, all outputs registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      count    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      h0       <= '0;
      h0_valid <= 1'b0;
    end else begin
      h0_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            count <= count + 1'b1;
            if (count == LAST_IDX) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The final product is still in flight; publish the same value stage 2 commits now
          h0       <= sum;
          h0_valid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_neuron_mac.sv
// Self-checking bench for mod_neuron_mac with four inputs per neuron.
// Directed vectors from a table, a reset-mid-neuron sequence, then random neurons against a reference model.
// All outputs are sampled 1 time unit after the rising edge.
module tb_mod_neuron_mac;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 64;

  logic          Clk;
  logic          Reset;
  logic          start;
  logic [AW-1:0] bias;
  logic          x_valid;
  logic [DW-1:0] x_in;
  logic [DW-1:0] w_in;
  logic          in_ready;
  logic          busy;
  logic [AW-1:0] h0;
  logic          h0_valid;
  logic          ovf;

  int n_cmp;
  int n_bad;
  logic [AW-1:0] prev_h0;

  mod_neuron_mac #(
    .N_INPUTS (N),
    .DATA_W   (DW),
    .ACC_W    (AW)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .bias     (bias),
    .x_valid  (x_valid),
    .x_in     (x_in),
    .w_in     (w_in),
    .in_ready (in_ready),
    .busy     (busy),
    .h0       (h0),
    .h0_valid (h0_valid),
    .ovf      (ovf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] b;
    logic [DW-1:0] x [N];
    logic [DW-1:0] w [N];
    int            gap;
    bit            noise;
    logic [AW-1:0] exp_h;
    bit            exp_o;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%h expected=0x%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference: bias plus each product in turn, clamped to the signed 64-bit range after every add
  function automatic void model(input logic [AW-1:0] b, input logic [DW-1:0] xa [N],
                                input logic [DW-1:0] wa [N], output logic [AW-1:0] h, output bit o);
    logic signed [127:0] a;
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    mx = (128'sd1 <<< 63) - 128'sd1;
    mn = -(128'sd1 <<< 63);
    a  = 128'($signed(b));
    o  = 1'b0;
    for (int i = 0; i < N; i++) begin
      a = a + 128'($signed(xa[i])) * 128'($signed(wa[i]));
      if (a > mx) begin a = mx; o = 1'b1; end
      if (a < mn) begin a = mn; o = 1'b1; end
    end
    h = a[AW-1:0];
  endfunction

  // One neuron from the IDLE cycle; returns in the IDLE cycle following DONE
  task automatic run_neuron(input string tag, input logic [AW-1:0] b,
                            input logic [DW-1:0] xa [N], input logic [DW-1:0] wa [N],
                            input int gap, input bit noise,
                            input logic [AW-1:0] exp_h, input bit exp_o);
    int g;
    start   = 1'b1;
    bias    = b;
    x_valid = 1'b1;          // must be ignored outside ACCUM
    x_in    = 16'h7abc;
    w_in    = 16'h6543;
    tick();
    check({tag, " in_ready entering ACCUM"}, in_ready, 1);
    check({tag, " busy entering ACCUM"}, busy, 1);
    check({tag, " h0 held from previous"}, h0, prev_h0);
    if (noise) bias = ~b;
    else start = 1'b0;
    for (int i = 0; i < N; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int j = 0; j < g; j++) begin
        x_valid = 1'b0;
        x_in    = 16'($urandom);
        w_in    = 16'($urandom);
        tick();
        check({tag, " in_ready during stall"}, in_ready, 1);
      end
      x_valid = 1'b1;
      x_in    = xa[i];
      w_in    = wa[i];
      tick();
    end
    x_valid = 1'b0;
    // cycle k+1: draining
    check({tag, " in_ready in DRAIN"}, in_ready, 0);
    check({tag, " h0_valid early"}, h0_valid, 0);
    tick();
    // cycle k+2: result
    check({tag, " h0_valid at k+2"}, h0_valid, 1);
    check({tag, " h0"}, h0, exp_h);
    check({tag, " ovf"}, ovf, exp_o);
    tick();
    start = 1'b0;
    check({tag, " h0_valid pulse width"}, h0_valid, 0);
    check({tag, " busy back in IDLE"}, busy, 0);
    check({tag, " h0 holds in IDLE"}, h0, exp_h);
    prev_h0 = exp_h;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] xa [N];
    logic [DW-1:0] wa [N];
    logic [AW-1:0] rb;
    logic [AW-1:0] eh;
    bit            eo;
    int            sel;

    n_cmp   = 0;
    n_bad   = 0;
    prev_h0 = '0;

    // basic: 10 + 2 + 12 - 30 - 56 = -62
    tbl[0].b = 64'd10;
    tbl[0].x = '{16'd1, 16'd3, 16'hFFFB, 16'd7};
    tbl[0].w = '{16'd2, 16'd4, 16'd6, 16'hFFF8};
    tbl[0].gap = 0; tbl[0].noise = 1'b0;
    tbl[0].exp_h = 64'hFFFF_FFFF_FFFF_FFC2; tbl[0].exp_o = 1'b0;
    // same data with three idle cycles before every beat
    tbl[1] = tbl[0];
    tbl[1].gap = 3;
    // start held high (with a different bias) through ACCUM/DRAIN/DONE must be ignored
    tbl[2] = tbl[0];
    tbl[2].gap = 1; tbl[2].noise = 1'b1;
    // saturation: (2^63-10)+100 clamps to 2^63-1, then three -5 steps from the clamp
    tbl[3].b = 64'h7FFF_FFFF_FFFF_FFF6;
    tbl[3].x = '{16'd100, 16'hFFFB, 16'hFFFB, 16'hFFFB};
    tbl[3].w = '{16'd1, 16'd1, 16'd1, 16'd1};
    tbl[3].gap = 0; tbl[3].noise = 1'b0;
    tbl[3].exp_h = 64'h7FFF_FFFF_FFFF_FFF0; tbl[3].exp_o = 1'b1;
    // negative extremes: 4 * (-32768)^2 = 2^32
    tbl[4].b = 64'd0;
    tbl[4].x = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tbl[4].w = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tbl[4].gap = 1; tbl[4].noise = 1'b0;
    tbl[4].exp_h = 64'h0000_0001_0000_0000; tbl[4].exp_o = 1'b0;

    Reset = 1'b1; start = 1'b0; bias = '0; x_valid = 1'b0; x_in = '0; w_in = '0;
    repeat (3) tick();
    Reset = 1'b0;
    check("reset h0", h0, 0);
    check("reset h0_valid", h0_valid, 0);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset ovf", ovf, 0);
    tick();
    check("idle in_ready", in_ready, 0);

    for (int v = 0; v < 5; v++) begin
      run_neuron($sformatf("vec%0d", v), tbl[v].b, tbl[v].x, tbl[v].w,
                 tbl[v].gap, tbl[v].noise, tbl[v].exp_h, tbl[v].exp_o);
    end

    // reset in the middle of a saturating neuron
    start = 1'b1; bias = 64'h7FFF_FFFF_FFFF_FFFF;
    tick();
    start = 1'b0; x_valid = 1'b1; x_in = 16'd1; w_in = 16'd1;
    tick();
    tick();
    x_valid = 1'b0;
    tick();
    check("midreset ovf before reset", ovf, 1);
    check("midreset busy before reset", busy, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midreset h0", h0, 0);
    check("midreset ovf", ovf, 0);
    check("midreset busy", busy, 0);
    check("midreset in_ready", in_ready, 0);
    check("midreset h0_valid", h0_valid, 0);
    prev_h0 = '0;
    run_neuron("after reset", tbl[0].b, tbl[0].x, tbl[0].w, 0, 1'b0, tbl[0].exp_h, 1'b0);

    // random neurons, biases occasionally pushed near the rails
    for (int r = 0; r < 24; r++) begin
      sel = int'($urandom_range(0, 3));
      rb  = {$urandom, $urandom};
      if (sel == 0) rb = 64'h7FFF_FFFF_C000_0000 + 64'($urandom_range(0, 65535));
      if (sel == 1) rb = 64'h8000_0000_3000_0000 - 64'($urandom_range(0, 65535));
      for (int i = 0; i < N; i++) begin
        xa[i] = 16'($urandom);
        wa[i] = 16'($urandom);
      end
      model(rb, xa, wa, eh, eo);
      run_neuron($sformatf("rand%0d", r), rb, xa, wa, -1, 1'b0, eh, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
